multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous, active-low.
REQ-004 opcode  in  7  RV32I opcode field from the IR; valid in DECODE onward.
REQ-005 br_taken  in  1  branch compare result from the ALU; sampled in EXEC.
REQ-006 mem_ready  in  1  memory completion for the current mem_req.
REQ-007 mem_req  out  1  memory access request.
REQ-008 mem_we  out  1  store qualifier for mem_req.
REQ-009 addr_sel  out  1  memory address source: 0 = PC, 1 = ALUOut.
REQ-010 ir_en, ab_en, alu_en, mdr_en  out  1 each  enables for the IR, A/B operand, ALUOut and MDR registers.
REQ-011 rf_we  out  1  register-file write enable.
REQ-012 wb_sel  out  2  write-back source: 0 = ALUOut, 1 = MDR, 2 = PC+4.
REQ-013 pc_en  out  1  PC register enable; pc_sel  out  1  PC source: 0 = PC+4, 1 = target.
REQ-014 retire  out  1  one-cycle pulse on instruction completion; retire_cnt  out  CNT_W  retired count.
REQ-015 state  out  3  current FSM state; trap  out  1  illegal-instruction flag.

Function
REQ-016 States and encoding SHALL be IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6; codes 7 SHALL go to IDLE.
REQ-017 IDLE: all enables low; next state FETCH unconditionally.
REQ-018 FETCH: mem_req=1, mem_we=0, addr_sel=0; hold while mem_ready=0; on mem_ready=1 assert ir_en and go to DECODE.
REQ-019 DECODE: ab_en=1; next EXEC.
REQ-020 EXEC: alu_en=1; BRANCH (1100011): pc_en=1, pc_sel=br_taken, retire=1, next FETCH.
REQ-021 EXEC next state: LOAD (0000011) / STORE (0100011) -> MEM; OP, OP-IMM, LUI, AUIPC, JAL, JALR -> WB.
REQ-022 MEM: mem_req=1, addr_sel=1, mem_we=1 for STORE only; hold while mem_ready=0.
REQ-023 MEM on mem_ready: LOAD -> mdr_en=1, next WB; STORE -> pc_en=1, pc_sel=0, retire=1, next FETCH.
REQ-024 WB: rf_we=1, pc_en=1, retire=1, next FETCH; wb_sel=1 for LOAD, 2 for JAL/JALR, else 0; pc_sel=1 for JAL/JALR, else 0.
REQ-025 All outputs other than state and retire_cnt SHALL be combinational decodes of state, opcode, br_taken, mem_ready; every enable not named for a state SHALL be 0.
REQ-026 Zero-wait latency: branch 3 cycles, store/ALU/jump/LUI/AUIPC 4, load 5 (FETCH to retire inclusive).
REQ-027 retire_cnt SHALL increment by 1 on each retire pulse and wrap from 2^CNT_W-1 to 0.
REQ-028 mem_req SHALL stay asserted with stable mem_we/addr_sel until mem_ready is sampled high.

Reset
REQ-029 rst_n low SHALL immediately force state=IDLE and retire_cnt=0, regardless of clk.
REQ-030 During reset all outputs SHALL be 0 (trap=0); first cycle after release is IDLE, mem_req first asserts in the following FETCH.
REQ-031 Reset asserted mid-access (FETCH/MEM with mem_req high) SHALL drop mem_req in the same delta; no retire pulse.

Configuration
REQ-032 Macro ILLEGAL_TRAP_EN defined: an opcode not listed in REQ-020/021 in EXEC SHALL go to TRAP; TRAP asserts trap=1, all enables 0, and holds until reset.
REQ-033 ILLEGAL_TRAP_EN undefined: unknown opcode in EXEC SHALL behave as NOP: pc_en=1, pc_sel=0, retire=1, next FETCH; trap tied 0; TRAP state unreachable.

Verification
REQ-034 Reset release, opcode=0110011, mem_ready=1 always -> states 0,1,2,3,5,1; rf_we and retire high in WB; retire_cnt=1.
REQ-035 LOAD with mem_ready low 3 cycles in MEM -> mem_req=1, addr_sel=1 held 4 cycles; mdr_en one cycle; WB wb_sel=1; 5+3 cycle latency.
REQ-036 BRANCH with br_taken=1 then =0 -> EXEC pc_en=1, pc_sel=1 then 0; no rf_we; retire_cnt +2.
REQ-037 JAL -> WB with wb_sel=2, pc_sel=1, rf_we=1; STORE -> mem_we=1 in MEM, no rf_we.
REQ-038 rst_n low during FETCH wait -> mem_req 0 asynchronously, state=0, retire_cnt=0.
REQ-039 Opcode 0000000: with ILLEGAL_TRAP_EN -> state=6, trap=1 persistent; without -> retire pulse, back to FETCH; CNT_W=4, 16 retires -> retire_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multicycle control FSM with retired-instruction counter.
// Define ILLEGAL_TRAP_EN to trap unknown opcodes in EXEC; otherwise they retire as NOPs.
module multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode_i,
  input  logic             br_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_en_o,
  output logic             ab_en_o,
  output logic             alu_en_o,
  output logic             mdr_en_o,
  output logic             rf_we_o,
  output logic [1:0]       wb_sel_o,
  output logic             pc_en_o,
  output logic             pc_sel_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] retire_cnt_o,
  output logic [2:0]       state_o,
  output logic             trap_o
);
  typedef enum logic [2:0] {IDLE = 3'd0, FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic is_ld, is_st, is_br, is_jmp, is_wb;
  assign is_ld  = opcode_i == 7'b0000011;
  assign is_st  = opcode_i == 7'b0100011;
  assign is_br  = opcode_i == 7'b1100011;
  assign is_jmp = opcode_i == 7'b1101111 || opcode_i == 7'b1100111;
  assign is_wb  = is_jmp || opcode_i inside {7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111};
  always_comb begin
    state_d    = IDLE;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_en_o    = 1'b0;
    ab_en_o    = 1'b0;
    alu_en_o   = 1'b0;
    mdr_en_o   = 1'b0;
    rf_we_o    = 1'b0;
    wb_sel_o   = 2'd0;
    pc_en_o    = 1'b0;
    pc_sel_o   = 1'b0;
    retire_o   = 1'b0;
    trap_o     = 1'b0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req_o = 1'b1;
        ir_en_o   = mem_ready_i;
        state_d   = mem_ready_i ? DECODE : FETCH;
      end
      DECODE: begin
        ab_en_o = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        alu_en_o = 1'b1;
        if (is_br) begin
          pc_en_o  = 1'b1;
          pc_sel_o = br_taken_i;
          retire_o = 1'b1;
          state_d  = FETCH;
        end else if (is_ld || is_st) begin
          state_d = MEM;
        end else if (is_wb) begin
          state_d = WB;
        end else begin
`ifdef ILLEGAL_TRAP_EN
          state_d = TRAP;
`else
          pc_en_o  = 1'b1;
          retire_o = 1'b1;
          state_d  = FETCH;
`endif
        end
      end
      MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = is_st;
        mdr_en_o   = mem_ready_i && is_ld;
        pc_en_o    = mem_ready_i && is_st;
        retire_o   = mem_ready_i && is_st;
        state_d    = !mem_ready_i ? MEM : is_st ? FETCH : WB;
      end
      WB: begin
        rf_we_o  = 1'b1;
        pc_en_o  = 1'b1;
        retire_o = 1'b1;
        wb_sel_o = is_ld ? 2'd1 : is_jmp ? 2'd2 : 2'd0;
        pc_sel_o = is_jmp;
        state_d  = FETCH;
      end
`ifdef ILLEGAL_TRAP_EN
      TRAP: begin
        trap_o  = 1'b1;
        state_d = TRAP;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  assign retire_cnt_d = retire_cnt_q + CNT_W'(retire_o);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      retire_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end
  assign state_o      = state_q;
  assign retire_cnt_o = retire_cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed-vector bench for multicycle_ctrl (CNT_W=4 to exercise counter wrap).
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [6:0] opcode = 7'b0110011;
  logic br_taken = 1'b0, mem_ready = 1'b1;
  logic mem_req, mem_we, addr_sel, ir_en, ab_en, alu_en, mdr_en, rf_we, pc_en, pc_sel, retire, trap;
  logic [1:0] wb_sel;
  logic [3:0] retire_cnt;
  logic [2:0] state;
  int nvec = 0, nmis = 0;
  multicycle_ctrl #(.CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode), .br_taken_i(br_taken), .mem_ready_i(mem_ready),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .addr_sel_o(addr_sel), .ir_en_o(ir_en), .ab_en_o(ab_en),
    .alu_en_o(alu_en), .mdr_en_o(mdr_en), .rf_we_o(rf_we), .wb_sel_o(wb_sel), .pc_en_o(pc_en),
    .pc_sel_o(pc_sel), .retire_o(retire), .retire_cnt_o(retire_cnt), .state_o(state), .trap_o(trap)
  );
  always #5 clk = ~clk;
  // {state, mem_req mem_we addr_sel, ir ab alu mdr, rf_we, wb_sel, pc_en pc_sel retire trap}
  logic [16:0] obs;
  assign obs = {state, mem_req, mem_we, addr_sel, ir_en, ab_en, alu_en, mdr_en, rf_we, wb_sel, pc_en, pc_sel, retire, trap};
  localparam logic [16:0] IDLE_V  = {3'd0, 14'b000_0000_0_00_0000};
  localparam logic [16:0] FETCH_W = {3'd1, 14'b100_0000_0_00_0000};
  localparam logic [16:0] FETCH_R = {3'd1, 14'b100_1000_0_00_0000};
  localparam logic [16:0] DEC     = {3'd2, 14'b000_0100_0_00_0000};
  localparam logic [16:0] EX_ALU  = {3'd3, 14'b000_0010_0_00_0000};
  localparam logic [16:0] EX_BT   = {3'd3, 14'b000_0010_0_00_1110};
  localparam logic [16:0] EX_BN   = {3'd3, 14'b000_0010_0_00_1010};
  localparam logic [16:0] MEM_LW  = {3'd4, 14'b101_0000_0_00_0000};
  localparam logic [16:0] MEM_LR  = {3'd4, 14'b101_0001_0_00_0000};
  localparam logic [16:0] MEM_SW  = {3'd4, 14'b111_0000_0_00_0000};
  localparam logic [16:0] MEM_SR  = {3'd4, 14'b111_0000_0_00_1010};
  localparam logic [16:0] WB_A    = {3'd5, 14'b000_0000_1_00_1010};
  localparam logic [16:0] WB_L    = {3'd5, 14'b000_0000_1_01_1010};
  localparam logic [16:0] WB_J    = {3'd5, 14'b000_0000_1_10_1110};
  localparam logic [16:0] TRAP_V  = {3'd6, 14'b000_0000_0_00_0001};
  task automatic test_reset();
    #3;
    nvec++; if (obs !== 17'd0 || retire_cnt !== 4'd0) begin nmis++; $display("FAIL reset_hold obs=%b cnt=%0d exp obs=%b cnt=0", obs, retire_cnt, IDLE_V); end
    @(posedge clk); #1;
    nvec++; if (obs !== 17'd0) begin nmis++; $display("FAIL reset_edge obs=%b exp=%b", obs, IDLE_V); end
    rst_n = 1'b1; #1;
    nvec++; if (obs !== IDLE_V) begin nmis++; $display("FAIL reset_idle obs=%b exp=%b", obs, IDLE_V); end
    @(posedge clk); #1;
  endtask
  task automatic test_alu();
    logic [18:0] v[$] = '{{2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_ALU}, {2'b10, WB_A}};
    opcode = 7'b0110011;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL alu cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== 4'd1 || state !== 3'd1) begin nmis++; $display("FAIL alu_cnt cnt=%0d st=%0d exp cnt=1 st=1", retire_cnt, state); end
  endtask
  task automatic test_branch();
    logic [18:0] v[$] = '{{2'b11, FETCH_R}, {2'b11, DEC}, {2'b11, EX_BT}, {2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_BN}};
    opcode = 7'b1100011;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL branch cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== 4'd3) begin nmis++; $display("FAIL branch_cnt cnt=%0d exp=3", retire_cnt); end
  endtask
  task automatic test_load_wait();
    logic [18:0] v[$] = '{{2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_ALU}, {2'b00, MEM_LW},
                          {2'b00, MEM_LW}, {2'b00, MEM_LW}, {2'b10, MEM_LR}, {2'b10, WB_L}};
    opcode = 7'b0000011;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL load cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== 4'd4) begin nmis++; $display("FAIL load_cnt cnt=%0d exp=4", retire_cnt); end
  endtask
  task automatic test_jal();
    logic [18:0] v[$] = '{{2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_ALU}, {2'b10, WB_J}};
    opcode = 7'b1101111;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL jal cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== 4'd5) begin nmis++; $display("FAIL jal_cnt cnt=%0d exp=5", retire_cnt); end
  endtask
  task automatic test_store();
    logic [18:0] v[$] = '{{2'b00, FETCH_W}, {2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_ALU},
                          {2'b00, MEM_SW}, {2'b10, MEM_SR}};
    opcode = 7'b0100011;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL store cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== 4'd6 || state !== 3'd1) begin nmis++; $display("FAIL store_cnt cnt=%0d st=%0d exp cnt=6 st=1", retire_cnt, state); end
  endtask
  task automatic test_wrap();
    opcode = 7'b0010011; mem_ready = 1'b1; br_taken = 1'b0;
    repeat (9) repeat (4) @(posedge clk);
    #1;
    nvec++; if (retire_cnt !== 4'd15) begin nmis++; $display("FAIL wrap_max cnt=%0d exp=15", retire_cnt); end
    repeat (4) @(posedge clk);
    #1;
    nvec++; if (retire_cnt !== 4'd0 || state !== 3'd1) begin nmis++; $display("FAIL wrap_zero cnt=%0d st=%0d exp cnt=0 st=1", retire_cnt, state); end
    #1;
  endtask
  task automatic test_reset_midfetch();
    opcode = 7'b0110011; mem_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #2;
      nvec++; if (obs !== FETCH_W) begin nmis++; $display("FAIL midfetch_wait obs=%b exp=%b", obs, FETCH_W); end
    end
    #1 rst_n = 1'b0; #1;
    nvec++; if (obs !== 17'd0 || retire_cnt !== 4'd0) begin nmis++; $display("FAIL midfetch_rst obs=%b cnt=%0d exp obs=0 cnt=0", obs, retire_cnt); end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1; #1;
    nvec++; if (obs !== IDLE_V) begin nmis++; $display("FAIL midfetch_idle obs=%b exp=%b", obs, IDLE_V); end
    @(posedge clk); #1;
  endtask
  task automatic test_illegal();
`ifdef ILLEGAL_TRAP_EN
    logic [18:0] v[$] = '{{2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_ALU}, {2'b10, TRAP_V}, {2'b10, TRAP_V}, {2'b10, TRAP_V}};
    logic [3:0] ecnt = 4'd0;
`else
    logic [18:0] v[$] = '{{2'b10, FETCH_R}, {2'b10, DEC}, {2'b10, EX_BN}, {2'b10, FETCH_R}};
    logic [3:0] ecnt = 4'd1;
`endif
    opcode = 7'b0000000;
    for (int i = 0; i < v.size(); i++) begin
      mem_ready = v[i][18]; br_taken = v[i][17]; #1;
      nvec++; if (obs !== v[i][16:0]) begin nmis++; $display("FAIL illegal cyc%0d obs=%b exp=%b", i, obs, v[i][16:0]); end
      @(posedge clk); #1;
    end
    nvec++; if (retire_cnt !== ecnt) begin nmis++; $display("FAIL illegal_cnt cnt=%0d exp=%0d", retire_cnt, ecnt); end
  endtask
  initial begin
    test_reset();
    test_alu();
    test_branch();
    test_load_wait();
    test_jal();
    test_store();
    test_wrap();
    test_reset_midfetch();
    test_illegal();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
